fetch_unit: RTL and testbench

- Instruction-fetch stage placed directly downstream of the PC address generator.
- Issues the current PC to instruction memory over a req/gnt/rvalid handshake and returns pc_four to the generator.
- Drives StallF so the PC advances only when a fetch is accepted or a redirect occurs.
- Discards wrong-path responses after a redirect and owns the IF/ID pipeline register, including a 1-entry response buffer for decode stalls.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_resp_buf.sv | 39 +++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] PC_INCR   = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_four;
        logic        valid;
    } if_id_t;

    function automatic logic [31:0] incr_pc(input logic [31:0] p);
        return p + PC_INCR;
    endfunction

endpackage

// File: rtl/fetch_resp_buf.sv
// One-entry skid buffer that parks a response arriving while decode is stalled.
module fetch_resp_buf
    import fetch_pkg::*;
(
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   push,
    input  logic   pop,
    input  logic   clear,
    input  if_id_t din,
    output if_id_t dout,
    output logic   full
);

    if_id_t data_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            full <= 1'b0;
        end else if (clear) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

    // NOTE: the payload is not reset; it is only ever read while full is set.
    always_ff @(posedge i_clk) begin
        if (push) begin
            data_q <= din;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage: issues the PC to instruction memory, squashes wrong-path responses, owns IF/ID.
module fetch_unit
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] pc,
    input  logic        br_sel,
    input  logic        StallD,
    input  logic        FlushD,
    output logic [31:0] pc_four,
    output logic        StallF,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc_four_d,
    output logic        valid_d
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_pend_q;
    if_id_t       if_id_q, if_id_d;
    if_id_t       resp_entry, rb_dout;
    logic         rb_full, rb_push, rb_pop;
    logic         deliver, fire;

    assign pc_four     = incr_pc(pc);
    assign o_imem_addr = pc;

    assign deliver    = (state_q == WAIT) && i_imem_rvalid && !br_sel;
    assign rb_push    = deliver && StallD && !FlushD;
    assign resp_entry = '{instr: i_imem_rdata, pc: pc_pend_q,
                          pc_four: incr_pc(pc_pend_q), valid: 1'b1};

    // A new request may go out only when the slot it would eventually land in is free.
    always_comb begin
        o_imem_req = 1'b0;
        if (!rb_full) begin
            case (state_q)
                FETCH:       o_imem_req = 1'b1;
                WAIT, KILL:  o_imem_req = i_imem_rvalid && !rb_push;
                default:     o_imem_req = 1'b0;
            endcase
        end
    end

    assign fire   = o_imem_req && i_imem_gnt;
    assign StallF = !fire && !br_sel;

    // NOTE: every variable driven here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (fire) state_d = br_sel ? KILL : WAIT;
            end
            WAIT: begin
                if (i_imem_rvalid) begin
                    if (fire) state_d = br_sel ? KILL : WAIT;
                    else      state_d = FETCH;
                end else if (br_sel) begin
                    state_d = KILL;
                end
            end
            KILL: begin
                if (i_imem_rvalid) begin
                    if (fire) state_d = br_sel ? KILL : WAIT;
                    else      state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q   <= FETCH;
            pc_pend_q <= '0;
        end else begin
            state_q <= state_d;
            if (fire && !br_sel) begin
                pc_pend_q <= pc;
            end
        end
    end

    // IF/ID update: flush, then stall, then buffered entry, then direct response, else bubble.
    always_comb begin
        if_id_d = if_id_q;
        rb_pop  = 1'b0;
        if (FlushD) begin
            if_id_d.valid = 1'b0;
            if_id_d.instr = NOP_INSTR;
        end else if (!StallD) begin
            if (rb_full) begin
                if_id_d = rb_dout;
                rb_pop  = 1'b1;
            end else if (deliver) begin
                if_id_d = resp_entry;
            end else begin
                if_id_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            if_id_q <= '{instr: NOP_INSTR, pc: 32'd0, pc_four: 32'd0, valid: 1'b0};
        end else begin
            if_id_q <= if_id_d;
        end
    end

    fetch_resp_buf u_resp_buf (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (rb_push),
        .pop   (rb_pop),
        .clear (br_sel),
        .din   (resp_entry),
        .dout  (rb_dout),
        .full  (rb_full)
    );

    assign instr_d   = if_id_q.instr;
    assign pc_d      = if_id_q.pc;
    assign pc_four_d = if_id_q.pc_four;
    assign valid_d   = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a queue-based model of fetch traffic.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        i_clk, i_rst;
    logic [31:0] pc;
    logic        br_sel, StallD, FlushD;
    logic [31:0] pc_four;
    logic        StallF, o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt, i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic [31:0] instr_d, pc_d, pc_four_d;
    logic        valid_d;

    fetch_unit dut (
        .i_clk(i_clk), .i_rst(i_rst), .pc(pc), .br_sel(br_sel),
        .StallD(StallD), .FlushD(FlushD), .pc_four(pc_four), .StallF(StallF),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_gnt(i_imem_gnt), .i_imem_rvalid(i_imem_rvalid),
        .i_imem_rdata(i_imem_rdata), .instr_d(instr_d), .pc_d(pc_d),
        .pc_four_d(pc_four_d), .valid_d(valid_d)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct { logic [31:0] pc; bit live; } fetch_t;
    typedef struct { int due; logic [31:0] data; } resp_t;
    typedef struct { logic [31:0] instr; logic [31:0] pc; logic [31:0] pc4; bit valid; } entry_t;

    fetch_t      outq[$];   // requests the model believes are in flight
    resp_t       memq[$];   // responses the memory will return
    entry_t      bufq[$];   // parked response, at most one
    entry_t      m_ifid;
    logic [31:0] m_pc;
    int          cyc, lat, lat_min, lat_max;
    bit          force_data;
    logic [31:0] forced_data;
    int          errors, checks;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        outq.delete();
        bufq.delete();
        m_ifid = '{instr: NOP, pc: 32'd0, pc4: 32'd0, valid: 1'b0};
        m_pc   = 32'd0;
    endtask

    // One clock cycle: drive inputs, check combinational outputs, advance model, check IF/ID.
    task automatic step(input bit br, input logic [31:0] bru, input bit sd, input bit fd, input bit g);
        bit rv, head_live, deliv, wbuf, ereq, fire;
        entry_t e;
        rv        = (memq.size() > 0) && (memq[0].due <= cyc);
        head_live = (outq.size() > 0) && outq[0].live;
        br_sel = br; StallD = sd; FlushD = fd; i_imem_gnt = g;
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? memq[0].data : $urandom();
        pc = m_pc;
        deliv = rv && head_live && !br;
        wbuf  = deliv && sd && !fd;
        ereq  = (bufq.size() == 0) && ((outq.size() == 0) || (rv && !wbuf));
        fire  = ereq && g;
        if (deliv) e = '{instr: memq[0].data, pc: outq[0].pc, pc4: outq[0].pc + 32'd4, valid: 1'b1};
        else       e = '{instr: NOP, pc: 32'd0, pc4: 32'd0, valid: 1'b0};
        #2;
        check("req", {31'd0, o_imem_req}, {31'd0, ereq});
        check("addr", o_imem_addr, m_pc);
        check("stallf", {31'd0, StallF}, {31'd0, !fire && !br});
        check("pc_four", pc_four, m_pc + 32'd4);
        @(posedge i_clk);
        if (rv) begin
            void'(memq.pop_front());
            if (outq.size() > 0) void'(outq.pop_front());
        end
        if (br) foreach (outq[i]) outq[i].live = 1'b0;
        if (fire) begin
            outq.push_back('{pc: m_pc, live: !br});
            memq.push_back('{due: cyc + lat, data: force_data ? forced_data : $urandom()});
            lat = $urandom_range(lat_max, lat_min);
        end
        if (fd) begin
            m_ifid.valid = 1'b0;
            m_ifid.instr = NOP;
        end else if (!sd) begin
            if (bufq.size() > 0) m_ifid = bufq.pop_front();
            else if (deliv)      m_ifid = e;
            else                 m_ifid.valid = 1'b0;
        end
        if (br)   bufq.delete();
        if (wbuf) bufq.push_back(e);
        if (br)        m_pc = bru;
        else if (fire) m_pc = m_pc + 32'd4;
        cyc++;
        #1;
        check("valid_d", {31'd0, valid_d}, {31'd0, m_ifid.valid});
        if (m_ifid.valid) begin
            check("pc_d", pc_d, m_ifid.pc);
            check("pc_four_d", pc_four_d, m_ifid.pc4);
            check("instr_d", instr_d, m_ifid.instr);
        end else if (fd) begin
            check("instr_d_flush", instr_d, NOP);
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0;
        lat_min = 1; lat_max = 1; lat = 1;
        force_data = 1'b0; forced_data = 32'd0;
        br_sel = 0; StallD = 0; FlushD = 0; i_imem_gnt = 0;
        i_imem_rvalid = 0; i_imem_rdata = 0; pc = 0;
        model_reset();
        i_rst = 1'b1;
        #1 i_rst = 1'b0;
        #1;
        check("rst_valid", {31'd0, valid_d}, 32'd0);
        check("rst_instr", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'd0);
        check("rst_pc_four_d", pc_four_d, 32'd0);
        @(negedge i_clk) i_rst = 1'b1;

        // Back-to-back 1-cycle fetches at 0, 4, 8.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1); check("t1_pc0", pc_d, 32'h0);
        step(0, 0, 0, 0, 1); check("t1_pc4", pc_d, 32'h4);
        step(0, 0, 0, 0, 1); check("t1_pc8", pc_d, 32'h8);

        // Redirect to 0x10, then hold off the grant for three cycles.
        step(1, 32'h10, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            check("t2_stallf", {31'd0, StallF}, 32'd1);
            check("t2_addr", o_imem_addr, 32'h10);
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("t2_pc_d", pc_d, 32'h10);
        check("t2_pc_four_d", pc_four_d, 32'h14);

        // Grant at 0x20 with a slow response, squashed by a redirect to 0x100.
        step(1, 32'h20, 0, 0, 0);
        lat = 3; force_data = 1'b1; forced_data = 32'hDEAD_BEEF;
        step(0, 0, 0, 0, 1);
        force_data = 1'b0; lat = 1;
        step(1, 32'h100, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("t3_valid", {31'd0, valid_d}, 32'd1);
        check("t3_pc_bru", pc_d, 32'h100);

        // Decode stall while 0x00A00093 returns: response parks in the buffer.
        force_data = 1'b1; forced_data = 32'h00A0_0093;
        step(0, 0, 0, 0, 1);
        force_data = 1'b0;
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 0, 1);
        check("t4_held_pc", pc_d, 32'h104);
        step(0, 0, 0, 0, 1);
        check("t4_instr", instr_d, 32'h00A0_0093);
        check("t4_valid", {31'd0, valid_d}, 32'd1);

        // Flush wins over stall; leaves a slow request outstanding for the reset test.
        lat = 4;
        step(0, 0, 1, 1, 1);
        check("t5_valid", {31'd0, valid_d}, 32'd0);
        check("t5_instr", instr_d, NOP);

        // Asynchronous reset in the middle of WAIT, then a stale response after release.
        step(0, 0, 0, 0, 0);
        #2 i_rst = 1'b0;
        #1;
        check("t6_valid", {31'd0, valid_d}, 32'd0);
        check("t6_instr", instr_d, NOP);
        check("t6_pc_d", pc_d, 32'd0);
        check("t6_pc_four_d", pc_four_d, 32'd0);
        check("t6_req", {31'd0, o_imem_req}, 32'd1);
        model_reset();
        #2 i_rst = 1'b1;
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
        check("t6_stale", {31'd0, valid_d}, 32'd0);

        // Randomized traffic.
        lat_min = 1; lat_max = 3; lat = 1;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(7, 0) == 0, $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(3, 0) == 0, $urandom_range(7, 0) == 0,
                 $urandom_range(3, 0) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
